// File: rtl/seg_capture.sv
// -----------------------------------------------------------------------------
// seg_capture
//
// Receive side of a 6-digit multiplexed 7-segment display. Watches the scanned
// segment bus, decodes each digit glyph back to a BCD nibble and publishes
// whole frames atomically.
//
// Scan handshake: there is no ready/valid pair on the input side; a "select
// change" (registered select differs from its previous registered value) is
// the only event. Digits must arrive in order 0,1,..,5 (wrapping 5->0), each
// select held long enough for SETTLE_CYCLES plus one sample cycle. On the
// output side frame_vld is a one-cycle strobe with no back-pressure:
// dout/dout_mask/point_n_out change only in the cycle frame_vld is high.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   seg_data     [7] dp (active-low), [6:0] segments g..a (active-low)
//   seg_sel_n    active-low one-hot digit select, bit0 = rightmost digit
//   dout         captured digits, digit k at dout[4k+3:4k]
//   dout_mask    1 = digit k showed a valid numeral
//   point_n_out  captured dp per digit, active-low
//   frame_vld    one-cycle pulse when the three outputs above update
//   glyph_err    one-cycle pulse on a non-blank, non-numeral pattern
//   seq_err      one-cycle pulse when the scan order is broken
//   stall        level, select frozen for TIMEOUT cycles
//   dbg_state    current FSM state (0 HUNT,1 SETTLE,2 SAMPLE,3 WAIT,4 FRAME)
// -----------------------------------------------------------------------------
module seg_capture #(
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT       = 60_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg_data,
    input  logic [5:0]  seg_sel_n,
    output logic [23:0] dout,
    output logic [5:0]  dout_mask,
    output logic [5:0]  point_n_out,
    output logic        frame_vld,
    output logic        glyph_err,
    output logic        seq_err,
    output logic        stall,
    output logic [2:0]  dbg_state
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_HUNT   = 3'd0,
        S_SETTLE = 3'd1,
        S_SAMPLE = 3'd2,
        S_WAIT   = 3'd3,
        S_FRAME  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [7:0]      r_seg;
    logic [5:0]      r_sel;
    logic [5:0]      r_sel_prev;
    logic [SW-1:0]   r_settle_cnt;
    logic [IW-1:0]   r_idle_cnt;
    logic            r_stall;
    logic [2:0]      r_pos;
    logic [23:0]     r_sh_dig;
    logic [5:0]      r_sh_mask;
    logic [5:0]      r_sh_pt;
    logic [23:0]     r_dout;
    logic [5:0]      r_mask;
    logic [5:0]      r_pt;
    logic            r_frame_vld;
    logic            r_glyph_err;
    logic            r_seq_err;

    logic            w_sel_chg;
    logic [5:0]      w_sel_act;
    logic            w_sel_legal;
    logic [2:0]      w_sel_pos;
    logic [2:0]      w_pos_exp;
    logic            w_next_ok;
    logic            w_settle_done;
    logic            w_timeout_hit;
    logic [3:0]      w_dec_nib;
    logic            w_dec_valid;
    logic            w_dec_bad;

    logic            w_enter_settle;
    logic            w_seq_set;
    logic            w_sample;
    logic            w_commit;
    logic            w_settle_run;

    // ---------------------------------------------------------------- input regs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg      <= 8'hFF;
            r_sel      <= 6'h3F;
            r_sel_prev <= 6'h3F;
        end else begin
            r_seg      <= seg_data;
            r_sel      <= seg_sel_n;
            r_sel_prev <= r_sel;
        end
    end

    // ---------------------------------------------------------------- select decode
    assign w_sel_chg   = (r_sel != r_sel_prev);
    assign w_sel_act   = ~r_sel;
    // Exactly one active bit: non-zero and clearing the lowest set bit leaves zero.
    assign w_sel_legal = (w_sel_act != 6'd0) &&
                         ((w_sel_act & (w_sel_act - 6'd1)) == 6'd0);

    always_comb begin
        w_sel_pos = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (w_sel_act[i]) begin
                w_sel_pos = 3'(i);
            end
        end
    end

    // After digit 5 (including right after FRAME) the next expected digit is 0.
    assign w_pos_exp     = (r_pos == 3'd5) ? 3'd0 : r_pos + 3'd1;
    assign w_next_ok     = w_sel_legal && (w_sel_pos == w_pos_exp);
    assign w_settle_done = (r_settle_cnt == SW'(SETTLE_CYCLES - 1));
    assign w_timeout_hit = !w_sel_chg && (r_idle_cnt == IW'(TIMEOUT - 1));

    // ---------------------------------------------------------------- glyph decode
    always_comb begin
        w_dec_nib   = 4'hF;
        w_dec_valid = 1'b1;
        w_dec_bad   = 1'b0;
        case (r_seg[6:0])
            7'h40:   w_dec_nib = 4'd0;
            7'h79:   w_dec_nib = 4'd1;
            7'h24:   w_dec_nib = 4'd2;
            7'h30:   w_dec_nib = 4'd3;
            7'h19:   w_dec_nib = 4'd4;
            7'h12:   w_dec_nib = 4'd5;
            7'h02:   w_dec_nib = 4'd6;
            7'h78:   w_dec_nib = 4'd7;
            7'h00:   w_dec_nib = 4'd8;
            7'h10:   w_dec_nib = 4'd9;
            7'h7F:   w_dec_valid = 1'b0;
            default: begin
                w_dec_valid = 1'b0;
                w_dec_bad   = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------- FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_HUNT: begin
                if (w_sel_chg && w_sel_legal && (w_sel_pos == 3'd0)) begin
                    w_state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_sel_chg) begin
                    w_state_next = S_HUNT;
                end else if (w_settle_done) begin
                    w_state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                w_state_next = (r_pos == 3'd5) ? S_FRAME : S_WAIT;
            end
            S_WAIT: begin
                if (w_sel_chg) begin
                    w_state_next = w_next_ok ? S_SETTLE : S_HUNT;
                end
            end
            S_FRAME: begin
                w_state_next = S_WAIT;
            end
            default: begin
                w_state_next = S_HUNT;
            end
        endcase
        // A frozen select abandons whatever frame was in progress.
        if (w_timeout_hit) begin
            w_state_next = S_HUNT;
        end
    end

    // ---------------------------------------------------------------- FSM: outputs
    always_comb begin
        w_enter_settle = 1'b0;
        w_seq_set      = 1'b0;
        w_sample       = 1'b0;
        w_commit       = 1'b0;
        w_settle_run   = 1'b0;
        case (r_state)
            S_HUNT: begin
                w_enter_settle = w_sel_chg && w_sel_legal && (w_sel_pos == 3'd0);
            end
            S_SETTLE: begin
                w_settle_run = 1'b1;
                w_seq_set    = w_sel_chg;
            end
            S_SAMPLE: begin
                w_sample = 1'b1;
            end
            S_WAIT: begin
                w_enter_settle = w_sel_chg && w_next_ok;
                w_seq_set      = w_sel_chg && !w_next_ok;
            end
            S_FRAME: begin
                w_commit = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ---------------------------------------------------------------- counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= '0;
            r_idle_cnt   <= '0;
            r_stall      <= 1'b0;
            r_pos        <= 3'd0;
        end else begin
            if (w_settle_run && !w_settle_done && !w_sel_chg) begin
                r_settle_cnt <= r_settle_cnt + SW'(1);
            end else begin
                r_settle_cnt <= '0;
            end

            if (w_sel_chg) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != IW'(TIMEOUT)) begin
                r_idle_cnt <= r_idle_cnt + IW'(1);
            end

            if (w_sel_chg) begin
                r_stall <= 1'b0;
            end else if (w_timeout_hit) begin
                r_stall <= 1'b1;
            end

            // Digit slot is latched on entry to SETTLE so SAMPLE is immune to
            // a select that moves in the sample cycle itself.
            if (w_enter_settle) begin
                r_pos <= w_sel_pos;
            end
        end
    end

    // ---------------------------------------------------------------- shadow + outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_dig    <= '0;
            r_sh_mask   <= '0;
            r_sh_pt     <= 6'h3F;
            r_dout      <= '0;
            r_mask      <= '0;
            r_pt        <= 6'h3F;
            r_frame_vld <= 1'b0;
            r_glyph_err <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (w_sample && (r_pos == 3'(i))) begin
                    r_sh_dig[4*i +: 4] <= w_dec_nib;
                    r_sh_mask[i]       <= w_dec_valid;
                    r_sh_pt[i]         <= r_seg[7];
                end
            end
            if (w_commit) begin
                r_dout <= r_sh_dig;
                r_mask <= r_sh_mask;
                r_pt   <= r_sh_pt;
            end
            r_frame_vld <= w_commit;
            r_glyph_err <= w_sample && w_dec_bad;
            r_seq_err   <= w_seq_set;
        end
    end

    assign dout        = r_dout;
    assign dout_mask   = r_mask;
    assign point_n_out = r_pt;
    assign frame_vld   = r_frame_vld;
    assign glyph_err   = r_glyph_err;
    assign seq_err     = r_seq_err;
    // Cleared combinationally in the very cycle the first new select is seen.
    assign stall       = r_stall && !w_sel_chg;
    assign dbg_state   = r_state;

endmodule

// File: doc/seg_capture.md
Name: seg_capture

Overview:
- Receive-side counterpart of the team's 6-digit multiplexed 7-segment driver.
- Watches the scanned segment bus (active-low segments plus dp, active-low one-hot digit select) and decodes each digit glyph back to a BCD nibble.
- Assembles complete frames into a 24-bit value with digit-valid and decimal-point vectors.
- Used for board self-check and loopback verification of the display path, and for monitoring an external scanned display.

Parameters:
- SETTLE_CYCLES, 4: cycles to wait after a select change before sampling the segments. Must be ≥3, because the driver's segment data lags its select by 2 cycles.
- TIMEOUT, 60_000: cycles with no select change before stall is declared.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- seg_data  input  8  [7] dp (active-low), [6:0] segments g..a (active-low)
- seg_sel_n  input  6  digit select, active-low one-hot, bit0 = rightmost digit
- dout  output  24  captured digits; digit k is dout[4k+3:4k]
- dout_mask  output  6  1 = digit k showed a valid numeral
- point_n_out  output  6  captured dp per digit, active-low
- frame_vld  output  1  one-cycle pulse when dout, dout_mask and point_n_out update
- glyph_err  output  1  one-cycle pulse when a sampled non-blank pattern is not a numeral
- seq_err  output  1  one-cycle pulse when the scan sequence is broken
- stall  output  1  level: select frozen for TIMEOUT cycles

Behaviour:
- Reset values: dout=0, dout_mask=0, point_n_out=6'h3F, frame_vld=0, glyph_err=0, seq_err=0, stall=0, FSM=HUNT, all counters 0.
- Input registration: seg_data and seg_sel_n are registered once (same clock domain).
- Select change: the registered select differs from its previous registered value.
- Select legality: legal only when exactly one bit is 0. Position p is the index of that 0.
- Decode of seg_data[6:0]:
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9 (hex).
  - 7F (blank) → nibble F, mask bit 0, no error.
  - Any other pattern → nibble F, mask bit 0, glyph_err pulse.
  - dp bit is captured as-is.
- Per-frame shadow: nibble, mask and dp are accumulated in shadow registers. Outputs update only at frame end, atomically.
- FSM states:
  - HUNT: wait for a select change to legal p=0, then go to SETTLE. Any other change is ignored silently.
  - SETTLE: count SETTLE_CYCLES. On terminal count go to SAMPLE. A select change during SETTLE raises seq_err and goes to HUNT.
  - SAMPLE (1 cycle): decode the current seg_data into shadow slot p. If p=5, go to FRAME; otherwise go to WAIT.
  - WAIT: wait for a select change. If the new select is legal with p_new = p+1, go to SETTLE. Otherwise raise seq_err and go to HUNT, discarding the shadow frame.
  - FRAME (1 cycle): copy the shadow to the outputs, pulse frame_vld, then go to WAIT with expected next p=0. The wrap 5→0 therefore continues into the next frame without passing through HUNT.
- Latency: frame_vld is asserted 2 cycles after the digit-5 sample cycle. The sample cycle itself is SETTLE_CYCLES+1 cycles after the registered select change.
- Stall:
  - The idle counter resets on every select change and saturates at TIMEOUT.
  - On reaching TIMEOUT: stall=1 and FSM → HUNT.
  - The first select change afterwards clears stall in the same cycle it is detected. That change is then handled by HUNT.
- Simultaneous events: a glyph_err and a seq_err in the same cycle both pulse. The frame with a glyph error still completes, carrying that digit as F with mask 0.
- Outputs hold their last frame until the next frame_vld. No partial updates.
- Reset mid-frame clears everything immediately. The first frame_vld after reset requires a full digit 0..5 scan starting from HUNT.

Test Plan:
1. Driver loopback, SHIFT_TIME=20, din=24'h123456, din_mask=6'h3F, point_n=6'h3F → after first full scan: dout=24'h123456, dout_mask=6'h3F, point_n_out=6'h3F. frame_vld pulses once every 120 cycles; no errors.
2. din_mask=6'b000111 → dout=24'hFFF456, dout_mask=6'b000111, glyph_err never asserted.
3. point_n=6'b111011 → point_n_out=6'b111011 on the next frame_vld; dout unchanged.
4. Force seg_data[6:0]=7'h7E during digit 2 of one frame → glyph_err single pulse. That frame gives dout[11:8]=F and dout_mask[2]=0; the next clean frame restores 4 and mask 6'h3F.
5. Drive select 111110→111101→110111 (skipping position 2) → seq_err pulse, no frame_vld for that scan. The next clean 0..5 scan gives frame_vld with correct data.
6. Hold select at 111011 for TIMEOUT=200 cycles → stall=1 at cycle 200 and outputs unchanged. Resume scanning → stall=0 on the first change, and a valid frame follows. Asserting rst_n low mid-frame → all outputs at reset values, no frame_vld from the interrupted scan.
